// File: rtl/mul_8x8_pipeline.sv
// Unsigned 8x8 pipelined multiplier: partial products, registered 8->4->2->1 adder tree, 16-bit product.
// Optional MUL8X8_INPUT_REG_EN adds an input register stage (latency 4 -> 5 stages).
module mul_8x8_pipeline (
  input  logic        clk_mul8x8,
  input  logic        rst_n,
  input  logic        vld_in,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] dout,
  output logic        vld_out
);

  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic        w_vld;
  logic [15:0] w_pp [8];

  logic [15:0] r_pp [8];
  logic        r_vld1;
  logic [15:0] r_s2 [4];
  logic        r_vld2;
  logic [15:0] r_s3 [2];
  logic        r_vld3;
  logic [15:0] r_dout;
  logic        r_vld_out;

`ifdef MUL8X8_INPUT_REG_EN
  logic [7:0] r_a_in;
  logic [7:0] r_b_in;
  logic       r_vld_in;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_mul8x8 or negedge rst_n) begin
    if (!rst_n) begin
      r_a_in   <= 8'h00;
      r_b_in   <= 8'h00;
      r_vld_in <= 1'b0;
    end else begin
      r_a_in   <= a;
      r_b_in   <= b;
      r_vld_in <= vld_in;
    end
  end

  assign w_a   = r_a_in;
  assign w_b   = r_b_in;
  assign w_vld = r_vld_in;
`else
  assign w_a   = a;
  assign w_b   = b;
  assign w_vld = vld_in;
`endif

  // NOTE: defaults first so no path through always_comb leaves w_pp unassigned (no latch).
  always_comb begin
    w_pp = '{default: 16'h0000};
    for (int i = 0; i < 8; i++) begin
      if (w_b[i]) w_pp[i] = {8'h00, w_a} << i;
    end
  end

  // NOTE: these arrays are pipeline flops, not RAM, so they clear on reset like any other register.
  always_ff @(posedge clk_mul8x8 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_pp[i] <= 16'h0000;
      for (int j = 0; j < 4; j++) r_s2[j] <= 16'h0000;
      for (int k = 0; k < 2; k++) r_s3[k] <= 16'h0000;
      r_vld1    <= 1'b0;
      r_vld2    <= 1'b0;
      r_vld3    <= 1'b0;
      r_dout    <= 16'h0000;
      r_vld_out <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) r_pp[i] <= w_pp[i];
      r_vld1 <= w_vld;
      // Sums never exceed 255*255, so 16-bit adders cannot overflow.
      for (int j = 0; j < 4; j++) r_s2[j] <= r_pp[2*j] + r_pp[2*j+1];
      r_vld2 <= r_vld1;
      for (int k = 0; k < 2; k++) r_s3[k] <= r_s2[2*k] + r_s2[2*k+1];
      r_vld3    <= r_vld2;
      r_dout    <= r_s3[0] + r_s3[1];
      r_vld_out <= r_vld3;
    end
  end

  assign dout    = r_dout;
  assign vld_out = r_vld_out;

endmodule

// File: tb/tb_mul_8x8_pipeline.sv
// Self-checking bench for mul_8x8_pipeline: reference is a*b delayed through a queue of pipeline depth.
// Honours MUL8X8_INPUT_REG_EN to select the expected latency.
module tb_mul_8x8_pipeline;

`ifdef MUL8X8_INPUT_REG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  typedef struct {
    logic [15:0] prod;
    logic        vld;
  } exp_t;

  logic        clk_mul8x8 = 1'b0;
  logic        rst_n      = 1'b0;
  logic        vld_in     = 1'b0;
  logic [7:0]  a          = 8'h00;
  logic [7:0]  b          = 8'h00;
  logic [15:0] dout;
  logic        vld_out;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  mul_8x8_pipeline dut (
    .clk_mul8x8(clk_mul8x8),
    .rst_n     (rst_n),
    .vld_in    (vld_in),
    .a         (a),
    .b         (b),
    .dout      (dout),
    .vld_out   (vld_out)
  );

  always #5 clk_mul8x8 = ~clk_mul8x8;

  // Model state after reset: nothing in flight, outputs read as zero until the first capture emerges.
  task automatic flush_model();
    exp_t z;
    z.prod = 16'h0000;
    z.vld  = 1'b0;
    q.delete();
    repeat (LAT - 1) q.push_back(z);
  endtask

  // Apply one operand pair for one edge; return what the outputs must show just after that edge.
  task automatic drive(input logic [7:0] ia, input logic [7:0] ib, input logic iv,
                       output logic [15:0] ed, output logic ev);
    exp_t e;
    exp_t o;
    a      = ia;
    b      = ib;
    vld_in = iv;
    @(posedge clk_mul8x8);
    #1;
    e.prod = 16'(ia) * 16'(ib);
    e.vld  = iv;
    q.push_back(e);
    o  = q.pop_front();
    ed = o.prod;
    ev = o.vld;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    a      = 8'hA5;
    b      = 8'h5A;
    vld_in = 1'b1;
    repeat (3) @(posedge clk_mul8x8);
    #1;
    if (dout !== 16'h0000 || vld_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset: dout=%h vld_out=%b expected dout=0000 vld_out=0", dout, vld_out);
    end
    n_vec++;
    @(negedge clk_mul8x8);
    rst_n = 1'b1;
    flush_model();
  endtask

  task automatic test_directed();
    logic [15:0] ed;
    logic        ev;
    logic [7:0]  da [3] = '{8'h02, 8'hFF, 8'h80};
    logic [7:0]  db [3] = '{8'h0F, 8'hFF, 8'h02};
    logic [15:0] dk [3] = '{16'h001E, 16'hFE01, 16'h0100};
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < LAT + 2; c++) begin
        drive(da[t], db[t], 1'b1, ed, ev);
        if (dout !== ed || vld_out !== ev) begin
          n_err++;
          $display("FAIL directed[%0d] cyc %0d: dout=%h vld=%b expected dout=%h vld=%b",
                   t, c, dout, vld_out, ed, ev);
        end
        n_vec++;
      end
      // Held long enough that the settled value must be the hand-computed product.
      if (dout !== dk[t] || vld_out !== 1'b1) begin
        n_err++;
        $display("FAIL directed_const[%0d]: dout=%h vld=%b expected dout=%h vld=1",
                 t, dout, vld_out, dk[t]);
      end
      n_vec++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ed;
    logic        ev;
    logic [7:0]  sa [4] = '{8'd1, 8'd3, 8'd16, 8'd200};
    logic [7:0]  sb [4] = '{8'd1, 8'd5, 8'd16, 8'd7};
    for (int c = 0; c < 4 + LAT; c++) begin
      if (c < 4) drive(sa[c], sb[c], 1'b1, ed, ev);
      else       drive(8'd0, 8'd9, 1'b0, ed, ev);
      if (dout !== ed || vld_out !== ev) begin
        n_err++;
        $display("FAIL b2b cyc %0d: dout=%0d vld=%b expected dout=%0d vld=%b",
                 c, dout, vld_out, ed, ev);
      end
      n_vec++;
    end
  endtask

  task automatic test_valid_toggle();
    logic [15:0] ed;
    logic        ev;
    logic        vp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5 + LAT; c++) begin
      if (c < 5) drive(8'(17 * c + 9), 8'(c + 3), vp[c], ed, ev);
      else       drive(8'(c), 8'hC3, 1'b0, ed, ev);
      if (dout !== ed || vld_out !== ev) begin
        n_err++;
        $display("FAIL vld_toggle cyc %0d: dout=%h vld=%b expected dout=%h vld=%b",
                 c, dout, vld_out, ed, ev);
      end
      n_vec++;
    end
  endtask

  task automatic test_zero_operands();
    logic [15:0] ed;
    logic        ev;
    for (int c = 0; c < 4 + LAT; c++) begin
      case (c)
        0:       drive(8'h00, 8'hFF, 1'b1, ed, ev);
        1:       drive(8'hFF, 8'h00, 1'b1, ed, ev);
        2:       drive(8'h00, 8'h00, 1'b1, ed, ev);
        default: drive(8'h01, 8'hFF, 1'b1, ed, ev);
      endcase
      if (dout !== ed || vld_out !== ev) begin
        n_err++;
        $display("FAIL zero_op cyc %0d: dout=%h vld=%b expected dout=%h vld=%b",
                 c, dout, vld_out, ed, ev);
      end
      n_vec++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] ed;
    logic        ev;
    for (int c = 0; c < 3; c++) begin
      drive(8'(8'hE0 + c), 8'hF3, 1'b1, ed, ev);
      if (dout !== ed || vld_out !== ev) begin
        n_err++;
        $display("FAIL mid_fill cyc %0d: dout=%h vld=%b expected dout=%h vld=%b",
                 c, dout, vld_out, ed, ev);
      end
      n_vec++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    if (dout !== 16'h0000 || vld_out !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_async: dout=%h vld_out=%b expected dout=0000 vld_out=0", dout, vld_out);
    end
    n_vec++;
    @(posedge clk_mul8x8);
    #1;
    if (dout !== 16'h0000 || vld_out !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_hold: dout=%h vld_out=%b expected dout=0000 vld_out=0", dout, vld_out);
    end
    n_vec++;
    @(negedge clk_mul8x8);
    rst_n = 1'b1;
    flush_model();
    for (int c = 0; c < LAT + 2; c++) begin
      drive(8'd13, 8'd11, 1'b1, ed, ev);
      if (dout !== ed || vld_out !== ev) begin
        n_err++;
        $display("FAIL post_reset cyc %0d: dout=%h vld=%b expected dout=%h vld=%b",
                 c, dout, vld_out, ed, ev);
      end
      n_vec++;
    end
  endtask

  task automatic test_random();
    logic [15:0] ed;
    logic        ev;
    for (int c = 0; c < 300; c++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ed, ev);
      if (dout !== ed || vld_out !== ev) begin
        n_err++;
        $display("FAIL random cyc %0d: dout=%h vld=%b expected dout=%h vld=%b",
                 c, dout, vld_out, ed, ev);
      end
      n_vec++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_valid_toggle();
    test_zero_operands();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_8x8_pipeline.md
Name: mul_8x8_pipeline

Overview:
- Unsigned 8x8 multiplier, fully pipelined, one new operand pair accepted every clock.
- Built as partial-product generation followed by a registered binary adder tree (8 -> 4 -> 2 -> 1).
- Produces a 16-bit product with a fixed latency.
- A valid bit travels alongside the data so downstream logic can qualify dout; arithmetic datapath block used by 8-bit DSP/arithmetic paths.

Parameters:
- none (widths fixed: 8-bit operands, 16-bit product)

Ports:
- clk_mul8x8  input  1   single clock, all state on rising edge
- rst_n  input  1   asynchronous active-low reset
- vld_in  input  1   operand pair on a/b is valid this cycle
- a  input  8   unsigned multiplicand
- b  input  8   unsigned multiplier
- dout  output  16  unsigned product a*b, registered
- vld_out  output  1   dout holds a valid product, registered

Behaviour:
- Interface: one clock (clk_mul8x8); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): every pipeline register cleared to 0.
  - dout=16'h0000, vld_out=0, held while rst_n=0.
  - Release is synchronous-safe; first capture is the first rising edge after rst_n=1.
- Stage 1 (capture edge E):
  - pp[i] = b[i] ? ({8'b0,a} << i) : 16'h0, for i=0..7.
  - Store the eight 16-bit partial products plus the valid bit.
- Stage 2 (edge E+1): four sums s2[j] = pp[2j] + pp[2j+1], 16-bit each.
- Stage 3 (edge E+2): two sums s3[k] = s2[2k] + s2[2k+1].
- Stage 4 (edge E+3): dout <= s3[0] + s3[1]; vld_out <= valid bit from stage 3.
- Latency:
  - Operands present at capture edge E appear on dout and vld_out immediately after edge E+3.
  - That is 4 register stages; result visible 3 cycles after capture.
- Throughput: one result per clock, no stall/backpressure; pipeline always advances.
- Width rule: all intermediate sums 16-bit; max product 255*255 = 65025 fits, so no overflow or truncation is possible.
- Valid handling:
  - Data path computes every cycle regardless of vld_in.
  - dout always reflects a*b of the operands captured 4 stages earlier, even when vld_in was 0.
  - vld_out is a pure 4-stage delay of vld_in; consumers qualify dout with vld_out.
- Operand changes: a/b may change every cycle; each edge's pair is independent, no cross-talk between in-flight products.
- Reset mid-operation: all in-flight products and valids are discarded.
  - dout=0 and vld_out=0 immediately on rst_n fall.
  - After release, outputs stay 0 until new operands propagate (3 edges after first capture).
- Operand-zero cases: a=0 or b=0 gives dout=0 with normal latency and valid.

Optional Feature:
- Macro: MUL8X8_INPUT_REG_EN
- Defined:
  - An extra register stage captures a, b, vld_in before partial-product generation (asynchronously reset to 0).
  - Latency becomes 5 stages: result visible immediately after edge E+4.
  - Eases input timing.
- Not defined: 4-stage pipeline exactly as in Behaviour.
- All other behaviour identical either way.

Test Plan:
- Reset then a=8'h02, b=8'h0F, vld_in=1 held -> after capture edge E+3: dout=16'h001E (30), vld_out=1; stays constant.
- a=8'hFF, b=8'hFF, vld_in=1 -> dout=16'hFE01 (65025) at E+3; a=8'h80, b=8'h02 -> 16'h0100.
- Back-to-back stream (1,1),(3,5),(16,16),(200,7) on consecutive edges -> dout sequence 1, 15, 256, 1400 on consecutive cycles, no gaps.
- Toggle vld_in 1,0,1,1,0 with changing operands -> vld_out shows the same pattern delayed 4 stages; dout still shows products for invalid slots.
- Assert rst_n=0 mid-stream with 3 products in flight -> dout=0 and vld_out=0 immediately; after release, first new product appears exactly at capture edge + 3.
- With MUL8X8_INPUT_REG_EN defined, repeat the 2x15 case -> dout=30 one cycle later than without the macro.
